// File: rtl/lif_ring_array.sv
// lif_ring_array: ring of leaky integrate-and-fire neurons with programmable weights, threshold, refractory period and spike counter
module lif_ring_array #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC = 2,
  parameter int THRESH_RST = 200,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  ext_in,
  input  logic [N-1:0]  ext_mask,
  input  logic          ring_en,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic [AW-1:0] rd_sel,
  input  logic          cnt_clr,
  output logic [W-1:0]  state_out,
  output logic [N-1:0]  spikes,
  output logic [15:0]   spike_cnt
);
  localparam int RW = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;
  localparam logic [RW-1:0] RC0 = RW'(REFRAC);
  localparam logic [W-1:0] TR = W'(THRESH_RST);
  localparam logic [AW:0] NL = (AW + 1)'(N);
  logic [W-1:0] s_q [N];
  logic [W-1:0] s_d [N];
  logic [W-1:0] w_q [N];
  logic [W-1:0] w_d [N];
  logic [RW-1:0] rc_q [N];
  logic [RW-1:0] rc_d [N];
  logic [N-1:0] spikes_q, spikes_d;
  logic [W-1:0] thr_q, thr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [W+1:0] sum;
  logic [15:0] pc;
  logic [16:0] inc;
  logic rf, fire;
  always_comb begin
    thr_d = (cfg_we && cfg_sel) ? cfg_data : thr_q;
    w_d = w_q;
    if (cfg_we && !cfg_sel && {1'b0, cfg_addr} < NL) w_d[cfg_addr] = cfg_data;
    pc = '0;
    sum = '0;
    rf = 1'b0;
    fire = 1'b0;
    spikes_d = '0;
    for (int i = 0; i < N; i++) begin
      pc = pc + 16'(spikes_q[i]);
      sum = {2'b0, s_q[i] - (s_q[i] >> LEAK_SHIFT)}
          + {2'b0, ext_mask[i] ? ext_in : {W{1'b0}}}
          + {2'b0, (ring_en && spikes_q[(i + N - 1) % N]) ? w_q[i] : {W{1'b0}}};
      rf = rc_q[i] != '0;
      fire = !rf && sum >= {2'b0, thr_q};
      spikes_d[i] = fire;
      rc_d[i] = rf ? rc_q[i] - RW'(1) : fire ? RC0 : '0;
      s_d[i] = (rf || fire) ? '0 : (|sum[W+1:W]) ? {W{1'b1}} : sum[W-1:0];
    end
    inc = {1'b0, cnt_q} + {1'b0, pc};
    cnt_d = cnt_clr ? 16'h0 : inc[16] ? 16'hFFFF : inc[15:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        s_q[i] <= '0;
        w_q[i] <= '1;
        rc_q[i] <= '0;
      end
      spikes_q <= '0;
      thr_q <= TR;
      cnt_q <= '0;
    end else begin
      s_q <= s_d;
      w_q <= w_d;
      rc_q <= rc_d;
      spikes_q <= spikes_d;
      thr_q <= thr_d;
      cnt_q <= cnt_d;
    end
  end
  assign state_out = ({1'b0, rd_sel} < NL) ? s_q[rd_sel] : '0;
  assign spikes = spikes_q;
  assign spike_cnt = cnt_q;
endmodule

// File: tb/tb_lif_ring_array.sv
// tb_lif_ring_array: directed self-checking bench for lif_ring_array
module tb_lif_ring_array;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] ext_in;
  logic [7:0] ext_mask;
  logic ring_en;
  logic cfg_we;
  logic cfg_sel;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [2:0] rd_sel;
  logic cnt_clr;
  logic [7:0] state_out;
  logic [7:0] spikes;
  logic [15:0] spike_cnt;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] leak_exp [7] = '{8'd100, 8'd150, 8'd175, 8'd188, 8'd194, 8'd197, 8'd199};
  logic [7:0] ring_exp [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  lif_ring_array dut (
    .clk(clk), .rst_n(rst_n), .ext_in(ext_in), .ext_mask(ext_mask), .ring_en(ring_en),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rd_sel(rd_sel), .cnt_clr(cnt_clr), .state_out(state_out), .spikes(spikes),
    .spike_cnt(spike_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    ext_in = '0;
    ext_mask = '0;
    ring_en = 1'b0;
    cfg_we = 1'b0;
    cfg_sel = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    rd_sel = '0;
    cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_spikes", spikes, 8'h00);
    chk("rst_cnt", spike_cnt, 16'h0);
    chk("rst_state", state_out, 8'h00);
    rst_n = 1'b1;
    ext_mask = 8'hFF;
    ext_in = 8'd100;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("leak", state_out, leak_exp[k]);
      chk("leak_nospk", spikes, 8'h00);
    end
    tick();
    chk("fire_spk", spikes, 8'hFF);
    chk("fire_state", state_out, 8'h00);
    tick();
    chk("ref1_spk", spikes, 8'h00);
    chk("ref1_state", state_out, 8'h00);
    chk("cnt8", spike_cnt, 16'd8);
    tick();
    chk("ref2_spk", spikes, 8'h00);
    chk("ref2_state", state_out, 8'h00);
    tick();
    chk("post_ref", state_out, 8'd100);
    rd_sel = 3'd5;
    #1;
    chk("rd_sel5", state_out, 8'd100);
    rd_sel = 3'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("gap", spikes, 8'h00);
    end
    tick();
    chk("spacing", spikes, 8'hFF);
    tick();
    chk("cnt16", spike_cnt, 16'd16);
    do_reset();
    cfg_we = 1'b1;
    cfg_sel = 1'b1;
    cfg_data = 8'd255;
    ext_in = 8'd200;
    tick();
    chk("old_thr", spikes, 8'hFF);
    cfg_we = 1'b0;
    tick();
    tick();
    chk("sat_ref", spikes, 8'h00);
    tick();
    chk("sat_s1", state_out, 8'd200);
    chk("sat_nospk", spikes, 8'h00);
    tick();
    chk("sat_spk", spikes, 8'hFF);
    ext_mask = 8'h01;
    ext_in = 8'd255;
    do_reset();
    tick();
    chk("ring_start", spikes, 8'h01);
    ext_in = 8'd0;
    ring_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("ring_walk", spikes, ring_exp[k]);
    end
    ring_en = 1'b0;
    tick();
    chk("ring_stop", spikes, 8'h00);
    tick();
    chk("ring_stop2", spikes, 8'h00);
    cfg_we = 1'b1;
    cfg_sel = 1'b0;
    cfg_addr = 3'd3;
    cfg_data = 8'd0;
    ext_in = 8'd255;
    ring_en = 1'b1;
    tick();
    chk("w3_start", spikes, 8'h01);
    cfg_we = 1'b0;
    ext_in = 8'd0;
    tick();
    chk("w3_hop1", spikes, 8'h02);
    tick();
    chk("w3_hop2", spikes, 8'h04);
    tick();
    chk("w3_block", spikes, 8'h00);
    tick();
    chk("w3_block2", spikes, 8'h00);
    ext_in = 8'd255;
    tick();
    ext_in = 8'd0;
    tick();
    chk("mid_wave", spikes, 8'h02);
    rst_n = 1'b0;
    cfg_we = 1'b1;
    cfg_sel = 1'b1;
    cfg_data = 8'd5;
    tick();
    chk("mid_rst_spk", spikes, 8'h00);
    chk("mid_rst_cnt", spike_cnt, 16'h0);
    chk("mid_rst_state", state_out, 8'h00);
    rst_n = 1'b1;
    cfg_we = 1'b0;
    ext_in = 8'd199;
    tick();
    chk("thr_restored", state_out, 8'd199);
    chk("thr_nospk", spikes, 8'h00);
    ext_in = 8'd255;
    tick();
    chk("rst_ring0", spikes, 8'h01);
    ext_in = 8'd0;
    tick();
    tick();
    tick();
    tick();
    chk("w3_restored", spikes, 8'h10);
    ring_en = 1'b0;
    ext_mask = 8'hFF;
    do_reset();
    cfg_we = 1'b1;
    cfg_sel = 1'b1;
    cfg_data = 8'd0;
    tick();
    chk("thr0_write", spikes, 8'h00);
    cfg_we = 1'b0;
    tick();
    chk("thr0_e1", spikes, 8'hFF);
    chk("thr0_c1", spike_cnt, 16'd0);
    tick();
    chk("thr0_c2", spike_cnt, 16'd8);
    tick();
    chk("thr0_c3", spike_cnt, 16'd8);
    tick();
    chk("thr0_e4", spikes, 8'hFF);
    tick();
    chk("thr0_c5", spike_cnt, 16'd16);
    for (int k = 0; k < 25000; k++) tick();
    chk("cnt_sat", spike_cnt, 16'hFFFF);
    for (int k = 0; k < 4 && spikes != 8'hFF; k++) tick();
    chk("clr_sync", spikes, 8'hFF);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr", spike_cnt, 16'h0);
    cnt_clr = 1'b0;
    tick();
    chk("cnt_after_clr", spike_cnt, 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lif_ring_array.md
Name: lif_ring_array

Overview:
- Parametrised ring of leaky integrate-and-fire neurons. Successor to the fixed 8-neuron, 8-bit ring.
- Adds per-neuron programmable synaptic weights, a programmable threshold, a refractory period and per-neuron external-input masking.
- Adds a ring-enable mode, a readout mux and a saturating aggregate spike counter.
- Sits behind the TT top wrapper: ui_in drives ext_in; config and readout go through the IO bus.

Parameters:
- N, 8: number of neurons (≥2).
- W, 8: membrane state, weight and threshold width.
- LEAK_SHIFT, 1: leak is state >> LEAK_SHIFT per cycle (1..W-1).
- REFRAC, 2: refractory cycles after a spike (0 = none).
- THRESH_RST, 200: threshold reset value.
- AW, $clog2(N): neuron address width (derived; do not override).

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- ext_in, input, W: external current, broadcast to all neurons.
- ext_mask, input, N: bit i=1 lets neuron i receive ext_in.
- ring_en, input, 1: 1 = neuron i receives weight[i] when neuron (i-1) mod N spiked last cycle.
- cfg_we, input, 1: configuration write strobe.
- cfg_sel, input, 1: 0 = write weight[cfg_addr]; 1 = write threshold (cfg_addr ignored).
- cfg_addr, input, AW: weight index.
- cfg_data, input, W: write data.
- rd_sel, input, AW: selects the neuron for state_out.
- cnt_clr, input, 1: clears spike_cnt.
- state_out, output, W: membrane state of neuron rd_sel (combinational mux of registers).
- spikes, output, N: registered spike flags, one per neuron.
- spike_cnt, output, 16: saturating total spike count.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all states, spikes, refractory counters and spike_cnt = 0
  - all weights = {W{1}}
  - threshold = THRESH_RST
  - reset takes priority over cfg writes and over counting, including mid-burst.
- Per-neuron update each cycle, when refractory counter rc[i] == 0:
  - leaked = s - (s >> LEAK_SHIFT)
  - drive = (ext_mask[i] ? ext_in : 0) + ((ring_en && spikes[(i+N-1)%N]) ? weight[i] : 0)
  - sum = leaked + drive, computed at W+2 bits, saturated to 2^W-1
  - if sum ≥ threshold: spikes[i] <= 1, s <= 0, rc <= REFRAC
  - else: spikes[i] <= 0, s <= sum.
- Refractory (rc[i] > 0): s <= 0, spikes[i] <= 0, rc decrements by 1, all inputs ignored.
- A spike pulse is exactly one cycle wide. The minimum spacing between spikes of one neuron is REFRAC+1 cycles.
- Ring hop latency is 1 cycle: a spike on neuron i at cycle t can cause a spike on neuron i+1 at cycle t+1. Neuron N-1 feeds neuron 0 (wrap-around).
- Threshold = 0: every non-refractory neuron spikes every eligible cycle. This is legal.
- cfg write:
  - takes effect at the next edge
  - the same-cycle evaluation uses the old threshold/weight
  - a cfg_addr ≥ N is ignored (no change).
- spike_cnt:
  - each cycle spike_cnt <= min(spike_cnt + popcount(spikes), 16'hFFFF)
  - cnt_clr=1 forces 0, with priority over the increment
  - counts the spikes vector registered in the previous cycle.
- state_out has no added latency versus the state register. rd_sel ≥ N returns 0.
- Arithmetic is unsigned throughout. No wrap anywhere: overflow saturates.

Test Plan (defaults unless stated):
- Leak/integrate, ext_mask=FF, ext_in=100, ring_en=0, after reset:
  - state_out(0) sequence 100,150,175,188,194,197,199
  - 8th edge: all spikes=FF, states 0
  - next cycle spike_cnt=8.
- Refractory, same stimulus continued:
  - spikes=00 and state 0 for 2 cycles after the spike cycle
  - next edge state=100
  - spike spacing = 10 cycles.
- Saturation: write threshold=255 (cfg_sel=1), ext_in=200 → states 200, then 255 (saturated, not 44) with spike on that edge.
- Ring propagation:
  - ext_mask=01, ext_in=255 for one cycle, then ext_in=0, ring_en=1
  - spikes walks 01,02,04,…,80,01 one hop per cycle and keeps circulating
  - with ring_en=0 the wave stops after the current hop
  - writing weight[3]=0 stops the wave at neuron 3.
- Counter: threshold=0, ext_mask=FF → spike_cnt rises by 8 per eligible cycle, saturates at FFFF; cnt_clr with an active spike yields 0 that cycle.
- Reset mid-operation: assert rst_n=0 during ring circulation with a modified weight → next edge all outputs 0, threshold=200, weights=FF.
